// File: rtl/speck_decrypt_core.sv
// ============================================================================
//  Module   : speck_decrypt_core
//  Brief    : Iterative SPECK128/128 decryptor, one round per clock with the
//             key schedule expanded forward then unwound alongside decryption.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module speck_decrypt_core #(
    parameter int ROUNDS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         signal_start,
    input  logic [127:0] key,
    input  logic [127:0] ciphertext,
    output logic [127:0] plaintext,
    output logic         finished,
    output logic         busy,
    output logic [3:0]   state_response
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_EXPAND  = 4'd1,
        ST_DECRYPT = 4'd2,
        ST_DONE    = 4'd3
    } state_t;

    localparam logic [4:0] C_LAST_EXPAND = 5'(ROUNDS - 2);

    function automatic logic [63:0] f_ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [63:0] f_rol(input logic [63:0] v, input int n);
        return (v << n) | (v >> (64 - n));
    endfunction

    state_t       r_state;
    logic [63:0]  r_k, r_l, r_x, r_y;
    logic [4:0]   r_i;
    logic [127:0] r_plaintext;
    logic         r_finished;
    logic         r_busy;

    logic [63:0]  w_l_fwd, w_k_fwd;
    logic [63:0]  w_y_inv, w_x_inv;
    logic [63:0]  w_k_inv, w_l_inv;
    logic [4:0]   w_i_dec;

    // Forward schedule step: produces k[i+1], l[i+1] from k[i], l[i].
    assign w_l_fwd = (r_k + f_ror(r_l, 8)) ^ {59'd0, r_i};
    assign w_k_fwd = f_rol(r_k, 3) ^ w_l_fwd;

    // Inverse round under k[i], and schedule rewound to k[i-1], l[i-1].
    assign w_y_inv = f_ror(r_x ^ r_y, 3);
    assign w_x_inv = f_rol((r_x ^ r_k) - w_y_inv, 8);
    assign w_i_dec = r_i - 5'd1;
    assign w_k_inv = f_ror(r_k ^ r_l, 3);
    assign w_l_inv = f_rol((r_l ^ {59'd0, w_i_dec}) - w_k_inv, 8);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_l         <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_i         <= '0;
            r_plaintext <= '0;
            r_finished  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_finished <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (signal_start) begin
                        r_k     <= key[63:0];
                        r_l     <= key[127:64];
                        r_x     <= ciphertext[127:64];
                        r_y     <= ciphertext[63:0];
                        r_i     <= 5'd0;
                        r_state <= ST_EXPAND;
                        r_busy  <= 1'b1;
                    end
                end
                ST_EXPAND: begin
                    r_l <= w_l_fwd;
                    r_k <= w_k_fwd;
                    r_i <= r_i + 5'd1;
                    if (r_i == C_LAST_EXPAND) begin
                        r_state <= ST_DECRYPT;
                    end
                end
                ST_DECRYPT: begin
                    r_y <= w_y_inv;
                    r_x <= w_x_inv;
                    r_k <= w_k_inv;
                    r_l <= w_l_inv;
                    r_i <= w_i_dec;
                    if (r_i == 5'd0) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_plaintext <= {r_x, r_y};
                    r_finished  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign plaintext      = r_plaintext;
    assign finished       = r_finished;
    assign busy           = r_busy;
    assign state_response = r_state;

endmodule

`default_nettype wire
